motoro3_pwm_capture: RTL and testbench

- Receive-side counterpart of the motor PWM generator. Samples a PWM line (gate-driver feedback, or the generator output looped back) and measures each pulse's high time and period.
- Accumulates delivered high-time per commutation step and reports the difference from the wanted accumulation.
- Counts pulses narrower than a programmable minimum. Results feed the position-loss correction path and debug registers.

---
 rtl/motoro3_pwm_capture.sv | 181 ++++++++++++++++++
 tb/tb_motoro3_pwm_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_pwm_capture.sv
// PWM receive-side capture: synchronizes and filters a PWM line, measures pulse high time and period,
// accumulates delivered high time per commutation step and counts short pulses.
module motoro3_pwm_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        capEnable,
    input  logic        pwmIn,
    input  logic        stepStart,
    input  logic [15:0] wantAcc,
    input  logic [11:0] minPulse,
    output logic        pulseValid,
    output logic [15:0] pulseHigh,
    output logic [15:0] pulsePeriod,
    output logic        stepDone,
    output logic [15:0] stepReal,
    output logic [15:0] stepLost,
    output logic [7:0]  minViolCnt,
    output logic        satErr
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FILT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0] VIOL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } capState_e;

    capState_e capState;

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncLvl;
    logic [FILT_W-1:0]      filtCnt;
    logic                   filtLvl;
    logic                   riseEdge;
    logic                   fallEdge;
    logic [CNT_W-1:0]       hiCnt;
    logic [CNT_W-1:0]       perCnt;
    logic [CNT_W-1:0]       hiLatch;
    logic [CNT_W-1:0]       acc;
    logic [CNT_W-1:0]       accView_c;
    logic                   accContrib_c;

    assign syncLvl = syncQ[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous PWM line.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], pwmIn};
        end
    end

    // Level filter: both edges see the same delay, so measured widths are preserved.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            filtCnt  <= '0;
            filtLvl  <= 1'b0;
            riseEdge <= 1'b0;
            fallEdge <= 1'b0;
        end else begin
            riseEdge <= 1'b0;
            fallEdge <= 1'b0;
            if (syncLvl != filtLvl) begin
                if (filtCnt == FILT_W'(FILT_LEN - 1)) begin
                    filtLvl  <= syncLvl;
                    filtCnt  <= '0;
                    riseEdge <= syncLvl;
                    fallEdge <= !syncLvl;
                end else begin
                    filtCnt <= filtCnt + FILT_W'(1);
                end
            end else begin
                filtCnt <= '0;
            end
        end
    end

    // Pulse measurement FSM.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            capState    <= IDLE;
            hiCnt       <= '0;
            perCnt      <= '0;
            hiLatch     <= '0;
            pulseValid  <= 1'b0;
            pulseHigh   <= '0;
            pulsePeriod <= '0;
            minViolCnt  <= '0;
            satErr      <= 1'b0;
        end else begin
            pulseValid <= 1'b0;
            if (!capEnable) begin
                capState <= IDLE;
                hiCnt    <= '0;
                perCnt   <= '0;
            end else begin
                case (capState)
                    IDLE: begin
                        hiCnt    <= '0;
                        perCnt   <= '0;
                        capState <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (riseEdge) begin
                            hiCnt    <= CNT_W'(1);
                            perCnt   <= CNT_W'(1);
                            capState <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (hiCnt == CNT_MAX || perCnt == CNT_MAX) begin
                            satErr   <= 1'b1;
                            capState <= WAIT_RISE;
                        end else if (fallEdge) begin
                            hiLatch  <= hiCnt;
                            perCnt   <= perCnt + CNT_W'(1);
                            capState <= LOW;
                            if (minPulse != '0 && hiCnt < CNT_W'(minPulse) && minViolCnt != VIOL_MAX) begin
                                minViolCnt <= minViolCnt + 8'd1;
                            end
                        end else begin
                            hiCnt  <= hiCnt + CNT_W'(1);
                            perCnt <= perCnt + CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (perCnt == CNT_MAX) begin
                            satErr   <= 1'b1;
                            capState <= WAIT_RISE;
                        end else if (riseEdge) begin
                            pulseValid  <= 1'b1;
                            pulseHigh   <= hiLatch;
                            pulsePeriod <= perCnt;
                            hiCnt       <= CNT_W'(1);
                            perCnt      <= CNT_W'(1);
                            capState    <= HIGH;
                        end else begin
                            perCnt <= perCnt + CNT_W'(1);
                        end
                    end
                    default: capState <= IDLE;
                endcase
            end
        end
    end

    assign accContrib_c = capEnable && filtLvl;
    assign accView_c    = capEnable ? acc : '0;

    // Step accumulator: the boundary cycle's sample seeds the next step.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            acc      <= '0;
            stepDone <= 1'b0;
            stepReal <= '0;
            stepLost <= '0;
        end else begin
            stepDone <= 1'b0;
            if (stepStart) begin
                stepDone <= 1'b1;
                stepReal <= accView_c;
                stepLost <= wantAcc - accView_c;
                acc      <= CNT_W'(accContrib_c);
            end else if (!capEnable) begin
                acc <= '0;
            end else if (accContrib_c && acc != CNT_MAX) begin
                acc <= acc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Directed bench for motoro3_pwm_capture: pulse measurement, filtering, short-pulse count,
// step accumulation, enable interruption, saturation and reset.
module tb_motoro3_pwm_capture;

    logic        clk;
    logic        nRst;
    logic        capEnable;
    logic        pwmIn;
    logic        stepStart;
    logic [15:0] wantAcc;
    logic [11:0] minPulse;
    logic        pulseValid;
    logic [15:0] pulseHigh;
    logic [15:0] pulsePeriod;
    logic        stepDone;
    logic [15:0] stepReal;
    logic [15:0] stepLost;
    logic [7:0]  minViolCnt;
    logic        satErr;

    int checks = 0;
    int errors = 0;

    int pvCount = 0;
    int sdCount = 0;
    int cyc = 0;
    int lastPvCyc = 0;
    int lastGap = 0;
    logic [15:0] lastHigh = '0;
    logic [15:0] lastPer = '0;
    logic [15:0] lastReal = '0;
    logic [15:0] lastLost = '0;
    logic pvPrev = 1'b0;
    logic sdPrev = 1'b0;
    int pvBase;
    int sdBase;

    motoro3_pwm_capture #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .capEnable  (capEnable),
        .pwmIn      (pwmIn),
        .stepStart  (stepStart),
        .wantAcc    (wantAcc),
        .minPulse   (minPulse),
        .pulseValid (pulseValid),
        .pulseHigh  (pulseHigh),
        .pulsePeriod(pulsePeriod),
        .stepDone   (stepDone),
        .stepReal   (stepReal),
        .stepLost   (stepLost),
        .minViolCnt (minViolCnt),
        .satErr     (satErr)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Strobe monitor, sampled on the rising edge away from the DUT's falling active edge.
    always @(posedge clk) begin
        cyc++;
        if (nRst) begin
            if (pulseValid) begin
                checkVal("pulseValidOneCycle", 32'(pvPrev), 32'd0);
                pvCount++;
                lastHigh  = pulseHigh;
                lastPer   = pulsePeriod;
                lastGap   = cyc - lastPvCyc;
                lastPvCyc = cyc;
            end
            if (stepDone) begin
                checkVal("stepDoneOneCycle", 32'(sdPrev), 32'd0);
                sdCount++;
                lastReal = stepReal;
                lastLost = stepLost;
            end
        end
        pvPrev = pulseValid;
        sdPrev = stepDone;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pwmPulses(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            pwmIn = 1'b1;
            waitCycles(hi);
            pwmIn = 1'b0;
            waitCycles(lo);
        end
    endtask

    task automatic pulseStep(input logic [15:0] want);
        @(posedge clk);
        stepStart = 1'b1;
        wantAcc   = want;
        @(posedge clk);
        stepStart = 1'b0;
        waitCycles(3);
    endtask

    initial begin
        nRst      = 1'b0;
        capEnable = 1'b0;
        pwmIn     = 1'b0;
        stepStart = 1'b0;
        wantAcc   = '0;
        minPulse  = '0;
        waitCycles(3);
        checkVal("rstPulseValid", 32'(pulseValid), 32'd0);
        checkVal("rstPulseHigh", 32'(pulseHigh), 32'd0);
        checkVal("rstStepDone", 32'(stepDone), 32'd0);
        checkVal("rstMinViol", 32'(minViolCnt), 32'd0);
        checkVal("rstSatErr", 32'(satErr), 32'd0);
        nRst = 1'b1;
        waitCycles(2);

        // Regular 32/256 train.
        capEnable = 1'b1;
        waitCycles(5);
        pvBase = pvCount;
        pwmPulses(32, 224, 5);
        waitCycles(20);
        checkVal("t1PulseCount", 32'(pvCount - pvBase), 32'd4);
        checkVal("t1PulseHigh", 32'(lastHigh), 32'd32);
        checkVal("t1PulsePeriod", 32'(lastPer), 32'd256);
        checkVal("t1Gap", 32'(lastGap), 32'd256);
        checkVal("t1SatErr", 32'(satErr), 32'd0);

        // Two-cycle glitches never pass the filter.
        pulseStep(16'd0);
        pvBase = pvCount;
        sdBase = sdCount;
        pwmPulses(2, 20, 6);
        pulseStep(16'd5);
        checkVal("t2PulseCount", 32'(pvCount - pvBase), 32'd0);
        checkVal("t2StepDone", 32'(sdCount - sdBase), 32'd1);
        checkVal("t2StepReal", 32'(lastReal), 32'd0);
        checkVal("t2StepLost", 32'(lastLost), 32'd5);

        // Short pulses against minPulse, then check disabled.
        minPulse = 12'd256;
        pwmPulses(100, 412, 5);
        waitCycles(20);
        checkVal("t3MinViol", 32'(minViolCnt), 32'd5);
        minPulse = 12'd0;
        pwmPulses(100, 412, 2);
        waitCycles(20);
        checkVal("t3MinViolHeld", 32'(minViolCnt), 32'd5);
        checkVal("t3PulseHigh", 32'(lastHigh), 32'd100);
        checkVal("t3PulsePeriod", 32'(lastPer), 32'd512);

        // Step accumulation over two windows.
        pulseStep(16'd0);
        pwmPulses(100, 100, 8);
        pulseStep(16'd1000);
        checkVal("t4StepReal1", 32'(lastReal), 32'd800);
        checkVal("t4StepLost1", 32'(lastLost), 32'd200);
        pwmPulses(100, 100, 8);
        pulseStep(16'd700);
        checkVal("t4StepReal2", 32'(lastReal), 32'd800);
        checkVal("t4StepLost2", 32'(lastLost), 32'hFF9C);

        // Enable dropped mid-HIGH; interrupted pulse must not be reported.
        pwmIn = 1'b1;
        waitCycles(20);
        pvBase = pvCount;
        capEnable = 1'b0;
        waitCycles(10);
        capEnable = 1'b1;
        waitCycles(20);
        pwmIn = 1'b0;
        waitCycles(206);
        pwmPulses(50, 206, 2);
        waitCycles(20);
        checkVal("t5PulseCount", 32'(pvCount - pvBase), 32'd1);
        checkVal("t5PulseHigh", 32'(lastHigh), 32'd50);
        checkVal("t5PulsePeriod", 32'(lastPer), 32'd256);

        // Step boundary while disabled reports zero delivered time.
        capEnable = 1'b0;
        waitCycles(2);
        pulseStep(16'd123);
        checkVal("t5DisStepReal", 32'(lastReal), 32'd0);
        checkVal("t5DisStepLost", 32'(lastLost), 32'd123);
        capEnable = 1'b1;
        waitCycles(5);

        // Counter saturation, recovery and reset.
        pvBase = pvCount;
        pwmIn = 1'b1;
        waitCycles(70000);
        checkVal("t6SatErr", 32'(satErr), 32'd1);
        checkVal("t6NoPulseOnSat", 32'(pvCount - pvBase), 32'd0);
        pwmIn = 1'b0;
        waitCycles(200);
        pvBase = pvCount;
        pwmPulses(32, 224, 3);
        waitCycles(20);
        checkVal("t6PulseCount", 32'(pvCount - pvBase), 32'd2);
        checkVal("t6PulseHigh", 32'(lastHigh), 32'd32);
        checkVal("t6PulsePeriod", 32'(lastPer), 32'd256);
        checkVal("t6SatSticky", 32'(satErr), 32'd1);
        nRst = 1'b0;
        @(posedge clk);
        checkVal("t6RstSatErr", 32'(satErr), 32'd0);
        checkVal("t6RstPulseHigh", 32'(pulseHigh), 32'd0);
        checkVal("t6RstPulsePeriod", 32'(pulsePeriod), 32'd0);
        checkVal("t6RstStepReal", 32'(stepReal), 32'd0);
        checkVal("t6RstStepLost", 32'(stepLost), 32'd0);
        checkVal("t6RstMinViol", 32'(minViolCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
